// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: control word layout and
// occupancy states of the two-entry skid buffer.
package ex_mem_pkg;

    localparam int CTRL_W = 6;

    // Field order matches in_ctrl: {zero,branch,mem_read,mem_write,mem_to_reg,reg_write}
    typedef struct packed {
        logic zero;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush. in_ready is
// registered so downstream back-pressure never reaches the upstream combinationally.
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output stage_state_t     state
);

    // Handshake rule on both sides: a transfer happens on a rising clk edge
    // exactly when valid and ready are both high; valid never depends on ready.

    stage_state_t     state_next;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             consume;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (consume) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_next     = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register: skid-buffered payload, bubble-gated control and a
// saturating stall-cycle counter for performance debug.
module ex_mem_stage_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_alu_result,
    input  logic [DATA_W-1:0]      in_store_data,
    input  logic [REG_AW-1:0]      in_write_reg,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_alu_result,
    output logic [DATA_W-1:0]      out_store_data,
    output logic [REG_AW-1:0]      out_write_reg,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = 2 * DATA_W + REG_AW + CTRL_W;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;
    stage_state_t     buf_state;
    ex_mem_ctrl_t     held_ctrl;
    logic             stalled;

    assign in_pay = {in_alu_result, in_store_data, in_write_reg, in_ctrl};

    pipe_skid_buf #(
        .WIDTH(PAY_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pay),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_pay),
        .state    (buf_state)
    );

    assign {out_alu_result, out_store_data, out_write_reg, held_ctrl} = out_pay;

    // A bubble must never look like a store or a register write downstream.
    assign out_ctrl = held_ctrl & {CTRL_W{out_valid}};

    assign stalled = (buf_state != EMPTY) & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
